// File: rtl/out_fifo_arbiter.sv
// out_fifo_arbiter: packet-level round-robin arbiter feeding the FT2232 output FIFO write port
module out_fifo_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT_CLKS = 255
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [8*NUM_REQ-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]   req_last_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic                 wr_out_fifo_en_o,
  output logic [7:0]           wr_out_fifo_data_o,
  input  logic                 wr_out_fifo_full_i,
  input  logic                 wr_out_fifo_afull_i,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic                 busy_o,
  output logic                 timeout_err_o
);
  localparam int IW = (NUM_REQ > 2) ? 2 : 1;
  typedef enum logic {IDLE, XFER} state_t;
  state_t state;
  logic [IW-1:0] last_grant, gidx, pick;
  logic [7:0] stall_cnt;
  logic blocked, abort, hs, hs_last;
  always_comb begin
    pick = last_grant;
    for (int i = NUM_REQ; i >= 1; i--)
      if (req_valid_i[IW'((int'(last_grant) + i) % NUM_REQ)]) pick = IW'((int'(last_grant) + i) % NUM_REQ);
  end
  assign blocked = wr_out_fifo_afull_i | wr_out_fifo_full_i;
  assign abort = (state == XFER) && (stall_cnt == 8'(TIMEOUT_CLKS));
  assign req_ready_o = (state == XFER && !blocked && !abort) ? (grant_o & req_valid_i) : '0;
  assign hs = |req_ready_o;
  assign hs_last = |(req_ready_o & req_last_i);
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state <= IDLE;
      grant_o <= '0;
      busy_o <= 1'b0;
      wr_out_fifo_en_o <= 1'b0;
      wr_out_fifo_data_o <= 8'h00;
      timeout_err_o <= 1'b0;
      stall_cnt <= 8'd0;
      last_grant <= IW'(NUM_REQ - 1);
      gidx <= '0;
    end else begin
      wr_out_fifo_en_o <= hs;
      timeout_err_o <= abort;
      if (hs) wr_out_fifo_data_o <= req_data_i[8*gidx +: 8];
      if (state == IDLE) begin
        stall_cnt <= 8'd0;
        if (|req_valid_i && !wr_out_fifo_afull_i) begin
          state <= XFER;
          busy_o <= 1'b1;
          gidx <= pick;
          grant_o <= '0;
          grant_o[pick] <= 1'b1;
        end
      end else if (abort || hs_last) begin
        state <= IDLE;
        busy_o <= 1'b0;
        grant_o <= '0;
        last_grant <= gidx;
        stall_cnt <= 8'd0;
      end else if (hs) begin
        stall_cnt <= 8'd0;
      end else if (!req_valid_i[gidx] && !blocked && stall_cnt != 8'hff) begin
        stall_cnt <= stall_cnt + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_out_fifo_arbiter.sv
// tb_out_fifo_arbiter: directed scoreboard bench for out_fifo_arbiter
module tb_out_fifo_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic [1:0] valid, last, ready, grant;
  logic [15:0] data;
  logic wr_en, full, afull, busy, terr;
  logic [7:0] wr_data;
  logic [8:0] q0[$], q1[$];
  logic [7:0] exp_q[$];
  logic hs0, hs1, en0, en1;
  int vectors = 0;
  int miscompares = 0;
  int rr_exp[6] = '{1, 1, 0, 2, 2, 0};

  out_fifo_arbiter #(.NUM_REQ(2), .TIMEOUT_CLKS(8)) dut (
    .clk_i(clk), .reset_i(rst), .req_valid_i(valid), .req_data_i(data),
    .req_last_i(last), .req_ready_o(ready), .wr_out_fifo_en_o(wr_en),
    .wr_out_fifo_data_o(wr_data), .wr_out_fifo_full_i(full),
    .wr_out_fifo_afull_i(afull), .grant_o(grant), .busy_o(busy),
    .timeout_err_o(terr)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $error("FAIL wr_extra: observed write %0h expected no write", wr_data);
      end else chk("wr_data", 32'(wr_data), 32'(exp_q.pop_front()));
    end
  end

  task automatic cyc();
    valid[0] = en0 && q0.size() > 0;
    valid[1] = en1 && q1.size() > 0;
    data[7:0] = valid[0] ? q0[0][7:0] : 8'h00;
    data[15:8] = valid[1] ? q1[0][7:0] : 8'h00;
    last[0] = valid[0] && q0[0][8];
    last[1] = valid[1] && q1[0][8];
    @(negedge clk);
    hs0 = ready[0];
    hs1 = ready[1];
    chk("ready_onehot", 32'($countones(ready) <= 1), 1);
    if (hs0) void'(q0.pop_front());
    if (hs1) void'(q1.pop_front());
    @(posedge clk);
    #1;
  endtask

  task automatic drain(int bound);
    for (int i = 0; i < bound && (q0.size() + q1.size()) > 0; i++) cyc();
    chk("drain", q0.size() + q1.size(), 0);
    cyc();
    cyc();
  endtask

  initial begin
    rst = 1'b1; full = 1'b0; afull = 1'b0; en0 = 1'b1; en1 = 1'b1;
    valid = '0; last = '0; data = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_grant", 32'(grant), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_en", 32'(wr_en), 0);
    chk("rst_data", 32'(wr_data), 0);
    chk("rst_terr", 32'(terr), 0);
    rst = 1'b0;
    // single requester, 4-byte packet
    q0 = '{9'h011, 9'h022, 9'h033, 9'h144};
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    cyc();
    chk("t1_grant", 32'(grant), 1);
    chk("t1_busy", 32'(busy), 1);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("t1_hs0", 32'(hs0), 1);
      chk("t1_hs1", 32'(hs1), 0);
      chk("t1_en", 32'(wr_en), 1);
    end
    chk("t1_busy_clr", 32'(busy), 0);
    chk("t1_grant_clr", 32'(grant), 0);
    cyc();
    // round robin from reset with simultaneous start
    rst = 1'b1; cyc(); rst = 1'b0;
    q0 = '{9'h0a0, 9'h1a1, 9'h0a0, 9'h1a1};
    q1 = '{9'h0b0, 9'h1b1, 9'h0b0, 9'h1b1};
    exp_q = '{8'ha0, 8'ha1, 8'hb0, 8'hb1, 8'ha0, 8'ha1, 8'hb0, 8'hb1};
    for (int i = 0; i < 12; i++) begin
      cyc();
      chk("t2_grant", 32'(grant), 32'(rr_exp[i % 6]));
    end
    drain(4);
    // backpressure mid-packet
    q0 = '{9'h051, 9'h052, 9'h053, 9'h154};
    exp_q.push_back(8'h51); exp_q.push_back(8'h52);
    exp_q.push_back(8'h53); exp_q.push_back(8'h54);
    cyc();
    chk("t3_grant", 32'(grant), 1);
    cyc();
    chk("t3_hs_first", 32'(hs0), 1);
    afull = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("t3_afull_hs", 32'(hs0), 0);
      chk("t3_afull_en", 32'(wr_en), 0);
      chk("t3_afull_terr", 32'(terr), 0);
    end
    afull = 1'b0; full = 1'b1;
    cyc();
    chk("t3_full_hs", 32'(hs0), 0);
    chk("t3_full_en", 32'(wr_en), 0);
    full = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t3_resume_hs", 32'(hs0), 1);
    end
    chk("t3_busy_clr", 32'(busy), 0);
    cyc();
    // timeout: req1 stalls after one byte while req0 waits
    q1 = '{9'h0c1};
    q0 = '{9'h0d0, 9'h1d1};
    exp_q.push_back(8'hc1); exp_q.push_back(8'hd0);
    exp_q.push_back(8'hd1); exp_q.push_back(8'he0);
    cyc();
    chk("t4_grant", 32'(grant), 2);
    cyc();
    chk("t4_hs1", 32'(hs1), 1);
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("t4_stall_terr", 32'(terr), 0);
      chk("t4_stall_grant", 32'(grant), 2);
    end
    cyc();
    chk("t4_terr", 32'(terr), 1);
    chk("t4_grant_clr", 32'(grant), 0);
    chk("t4_busy_clr", 32'(busy), 0);
    chk("t4_no_write", 32'(wr_en), 0);
    q1.push_back(9'h1e0);
    cyc();
    chk("t4_terr_once", 32'(terr), 0);
    chk("t4_regrant", 32'(grant), 1);
    drain(20);
    // single-byte packet, then reset mid-packet
    q0 = '{9'h177};
    exp_q.push_back(8'h77);
    cyc();
    chk("t5_grant", 32'(grant), 1);
    cyc();
    chk("t5_hs", 32'(hs0), 1);
    chk("t5_busy_clr", 32'(busy), 0);
    q1 = '{9'h080, 9'h081, 9'h082, 9'h183};
    exp_q.push_back(8'h80);
    cyc();
    chk("t6_grant", 32'(grant), 2);
    cyc();
    chk("t6_hs_g0", 32'(hs1), 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("t6_rst_en", 32'(wr_en), 0);
    chk("t6_rst_grant", 32'(grant), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_data", 32'(wr_data), 0);
    chk("t6_rst_terr", 32'(terr), 0);
    q0 = '{9'h190};
    exp_q.push_back(8'h90); exp_q.push_back(8'h82); exp_q.push_back(8'h83);
    cyc();
    chk("t6_req0_first", 32'(grant), 1);
    drain(20);
    chk("exp_left", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
